// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Each digit is preceded by an all-anodes-off dead interval to suppress ghosting.
// New display data is staged and only committed to the shadow copy at the start
// of a frame, so a frame never shows a mixture of old and new data.
module seg7_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int ON_CYC   = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] data,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank,
  input  logic               lzs_en,
  input  logic               load,
  output logic [3:0]         nib,
  output logic [N_DIG-1:0]   an,
  output logic               dp_n,
  output logic               frame_tick
);

  localparam int IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int CNT_MAX = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;

  logic [4*N_DIG-1:0] shadow_data_r, staged_data_r, eff_data_s;
  logic [N_DIG-1:0]   shadow_dp_r, staged_dp_r, eff_dp_s;
  logic [N_DIG-1:0]   shadow_blank_r, staged_blank_r, eff_blank_s;
  logic               pending_r;

  logic               enter_on_s;
  logic               boundary_s;
  logic [N_DIG-1:0]   sup_s;
  logic [N_DIG-1:0]   an_sel_s;
  logic               dark_s;
  logic [3:0]         nib_sel_s;

  // Leading-zero mask: digit i (i>=1) is suppressed while it and every higher
  // digit hold 0 with the decimal point clear. Digit 0 is never suppressed.
  function automatic logic [N_DIG-1:0] lzs_mask(input logic [4*N_DIG-1:0] d,
                                                input logic [N_DIG-1:0]   p);
    logic [N_DIG-1:0] m;
    logic             z;
    m = '0;
    z = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      z    = z & (d[4*i +: 4] == 4'h0) & ~p[i];
      m[i] = z;
    end
    return m;
  endfunction

  // Next-state logic: dead/on sequencing, per-state cycle counter, digit index.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r + CNT_W'(1);
    case (state_r)
      ST_DEAD: begin
        if (cnt_r == DEAD_LAST) begin
          state_s = ST_ON;
          cnt_s   = '0;
        end else begin
          state_s = ST_DEAD;
        end
      end
      ST_ON: begin
        if (cnt_r == ON_LAST) begin
          state_s = ST_DEAD;
          cnt_s   = '0;
          idx_s   = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end else begin
          state_s = ST_ON;
        end
      end
      default: begin
        state_s = ST_DEAD;
        cnt_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  // Data view for the digit about to be shown; at the frame boundary a load in
  // that very cycle wins, otherwise pending staged data, otherwise the shadow.
  always_comb begin
    enter_on_s  = (state_r == ST_DEAD) && (cnt_r == DEAD_LAST);
    boundary_s  = enter_on_s && (idx_r == '0);
    eff_data_s  = shadow_data_r;
    eff_dp_s    = shadow_dp_r;
    eff_blank_s = shadow_blank_r;
    if (boundary_s && load) begin
      eff_data_s  = data;
      eff_dp_s    = dp_in;
      eff_blank_s = blank;
    end else if (boundary_s && pending_r) begin
      eff_data_s  = staged_data_r;
      eff_dp_s    = staged_dp_r;
      eff_blank_s = staged_blank_r;
    end else begin
      eff_data_s  = shadow_data_r;
      eff_dp_s    = shadow_dp_r;
      eff_blank_s = shadow_blank_r;
    end
    for (int i = 0; i < N_DIG; i++) begin
      an_sel_s[i] = (idx_r == IDX_W'(i)) ? 1'b0 : 1'b1;
    end
    sup_s     = lzs_mask(eff_data_s, eff_dp_s);
    dark_s    = eff_blank_s[idx_r] | (lzs_en & sup_s[idx_r]);
    nib_sel_s = eff_data_s[idx_r*4 +: 4];
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_DEAD;
      idx_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
    end
  end

  // Staging of loaded data and commit to the shadow copy at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_r  <= '0;
      shadow_dp_r    <= '0;
      shadow_blank_r <= '0;
      staged_data_r  <= '0;
      staged_dp_r    <= '0;
      staged_blank_r <= '0;
      pending_r      <= 1'b0;
    end else if (boundary_s) begin
      shadow_data_r  <= eff_data_s;
      shadow_dp_r    <= eff_dp_s;
      shadow_blank_r <= eff_blank_s;
      pending_r      <= 1'b0;
    end else if (load) begin
      staged_data_r  <= data;
      staged_dp_r    <= dp_in;
      staged_blank_r <= blank;
      pending_r      <= 1'b1;
    end else begin
      pending_r      <= pending_r;
    end
  end

  // Registered display outputs: digit values latched on entry to ON, anodes
  // forced off for the whole dead interval, nib/dp_n held while dead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      nib        <= 4'h0;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary_s;
      if (enter_on_s) begin
        nib  <= nib_sel_s;
        an   <= dark_s ? {N_DIG{1'b1}} : an_sel_s;
        dp_n <= dark_s ? 1'b1 : ~eff_dp_s[idx_r];
      end else if (state_s == ST_DEAD) begin
        an   <= '1;
      end else begin
        an   <= an;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N_DIG=4, ON_CYC=4, DEAD_CYC=2).
// Each scenario queues the expected per-cycle outputs for whole frames; a
// monitor pops one expectation per clock and compares it to the DUT outputs.
module tb_seg7_scan_ctrl;

  localparam int N_DIG    = 4;
  localparam int ON_CYC   = 4;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = N_DIG * (ON_CYC + DEAD_CYC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        lzs_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp_n;
    logic       ft;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [3:0]  last_nib = 4'h0;
  logic        last_dpn = 1'b1;

  seg7_scan_ctrl #(.N_DIG(N_DIG), .ON_CYC(ON_CYC), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank),
    .lzs_en(lzs_en), .load(load), .nib(nib), .an(an), .dp_n(dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: one expectation per clock while enabled.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scan t=%0t: no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        if ({an, nib, dp_n, frame_tick} !== e) begin
          n_fail++;
          $display("FAIL scan t=%0t: got an=%b nib=%h dp_n=%b tick=%b, want an=%b nib=%h dp_n=%b tick=%b",
                   $time, an, nib, dp_n, frame_tick, e.an, e.nib, e.dp_n, e.ft);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Queue expectations for frame offsets from..upto of a frame displaying d/dp/bl.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz,
                            input int from, input int upto);
    exp_t       x;
    logic [3:0] sup;
    logic       z;
    logic       dark;
    int         off;
    sup = 4'b0000;
    z   = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      z      = z && (d[4*i +: 4] == 4'h0) && !dp[i];
      sup[i] = z;
    end
    off = 0;
    for (int dig = 0; dig < 4; dig++) begin
      for (int c = 0; c < DEAD_CYC; c++) begin
        x = '{an: 4'b1111, nib: last_nib, dp_n: last_dpn, ft: 1'b0};
        if (off >= from && off <= upto) exp_q.push_back(x);
        off++;
      end
      dark     = bl[dig] || (lz && sup[dig]);
      last_nib = d[4*dig +: 4];
      last_dpn = dark ? 1'b1 : !dp[dig];
      for (int c = 0; c < ON_CYC; c++) begin
        x.an   = dark ? 4'b1111 : ~(4'b0001 << dig);
        x.nib  = last_nib;
        x.dp_n = last_dpn;
        x.ft   = (dig == 0 && c == 0);
        if (off >= from && off <= upto) exp_q.push_back(x);
        off++;
      end
    end
  endtask

  // One-cycle load strobe at a given frame offset; inputs then go to junk.
  task automatic apply_load(input int base, input int off, input logic [15:0] d,
                            input logic [3:0] dp, input logic [3:0] bl);
    run_to(base + off);
    data = d; dp_in = dp; blank = bl; load = 1'b1;
    run_to(base + off + 1);
    load = 1'b0; data = 16'hFFFF; dp_in = 4'hF; blank = 4'hF;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++;
    if (nib !== 4'h0) begin n_fail++; $display("FAIL reset_nib: got %h want 0", nib); end
    n_checks++;
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dp_n: got %b want 1", dp_n); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    rst = 1'b0;
    cyc = 0;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 1, FRAME - 1);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    mon_en = 1'b1;
    run_to(2 * FRAME - 1);
  endtask

  task automatic test_load_mid();
    int base;
    base = cyc + 1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    push_frame(16'h1234, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    apply_load(base, 10, 16'h1234, 4'h0, 4'h0);
    run_to(base + 2 * FRAME - 1);
  endtask

  task automatic test_lzs();
    int base;
    base = cyc + 1;
    lzs_en = 1'b1;
    push_frame(16'h1234, 4'h0, 4'h0, 1'b1, 0, FRAME - 1);
    push_frame(16'h0070, 4'h0, 4'h0, 1'b1, 0, FRAME - 1);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 0, FRAME - 1);
    apply_load(base, 10, 16'h0070, 4'h0, 4'h0);
    apply_load(base, FRAME + 10, 16'h0000, 4'h0, 4'h0);
    run_to(base + 3 * FRAME - 1);
    lzs_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    base = cyc + 1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    push_frame(16'h5555, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    push_frame(16'h9876, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    apply_load(base, 5, 16'hAAAA, 4'h0, 4'h0);
    apply_load(base, 12, 16'h5555, 4'h0, 4'h0);
    apply_load(base, 2 * FRAME + 1, 16'h9876, 4'h0, 4'h0);
    run_to(base + 3 * FRAME - 1);
  endtask

  task automatic test_blank_dp();
    int base;
    base = cyc + 1;
    push_frame(16'h9876, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    push_frame(16'h4321, 4'b0001, 4'b0010, 1'b0, 0, FRAME - 1);
    apply_load(base, 8, 16'h4321, 4'b0001, 4'b0010);
    run_to(base + 2 * FRAME - 1);
  endtask

  task automatic test_reset_mid();
    int base;
    base = cyc + 1;
    push_frame(16'h4321, 4'b0001, 4'b0010, 1'b0, 0, 15);
    apply_load(base, 3, 16'hBEEF, 4'h0, 4'h0);
    run_to(base + 15);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an: got %b want 1111", an); end
    n_checks++;
    if (nib !== 4'h0) begin n_fail++; $display("FAIL midrst_nib: got %h want 0", nib); end
    n_checks++;
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL midrst_dp_n: got %b want 1", dp_n); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_queue: got %0d left want 0", exp_q.size()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    last_nib = 4'h0;
    last_dpn = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 1, FRAME - 1);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 0, FRAME - 1);
    mon_en = 1'b1;
    run_to(2 * FRAME - 1);
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL end_queue: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_lzs();
    test_back_to_back();
    test_blank_dp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
